// File: rtl/arbitro_alu.sv
// arbitro_alu: round-robin arbiter sharing one registered add/multiply unit between two clients
module arbitro_alu #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic         op0,
    input  logic         op1,
    output logic         ack0,
    output logic         ack1,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] res0,
    output logic [W-1:0] res1,
    output logic         busy,
    output logic [W-1:0] alu_abc,
    output logic [W-1:0] alu_xis,
    output logic         alu_H,
    input  logic [W-1:0] alu_resultado
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
    state_t state, state_n;
    logic gnt, last, grant, win;
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= state_n;
    // On a tie the client that was not served last wins
    always_comb begin
        grant   = (state == IDLE) && (req0 || req1);
        win     = (req0 && req1) ? ~last : req1;
        state_n = state == IDLE  ? (grant ? ISSUE : IDLE) :
                  state == ISSUE ? CAPTURE : IDLE;
    end
    assign busy = state != IDLE;
    always_ff @(posedge clk)
        if (rst) begin
            gnt     <= 1'b0;
            last    <= 1'b1;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            res0    <= '0;
            res1    <= '0;
            alu_abc <= '0;
            alu_xis <= '0;
            alu_H   <= 1'b0;
        end else begin
            ack0  <= grant && !win;
            ack1  <= grant && win;
            done0 <= (state == CAPTURE) && !gnt;
            done1 <= (state == CAPTURE) && gnt;
            if (grant) begin
                gnt     <= win;
                alu_abc <= win ? a1 : a0;
                alu_xis <= win ? b1 : b0;
                alu_H   <= win ? op1 : op0;
            end
            if (state == CAPTURE) begin
                last <= gnt;
                if (gnt) res1 <= alu_resultado;
                else     res0 <= alu_resultado;
            end
        end
endmodule

// File: tb/tb_arbitro_alu.sv
// tb_arbitro_alu: directed checks of arbitration, timing, wraparound and reset of arbitro_alu
module tb_arbitro_alu;
    localparam int W = 16;
    logic clk = 1'b0, rst = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic ack0, ack1, done0, done1, busy, alu_H;
    logic [W-1:0] res0, res1, alu_abc, alu_xis, alu_resultado;
    logic [W-1:0] er0 = '0, er1 = '0;
    int total = 0, bad = 0;

    arbitro_alu #(.W(W)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .res0(res0), .res1(res1), .busy(busy),
        .alu_abc(alu_abc), .alu_xis(alu_xis), .alu_H(alu_H),
        .alu_resultado(alu_resultado)
    );

    always #5 clk = ~clk;

    // Shared arithmetic unit: registered, truncated to W bits
    always @(posedge clk)
        alu_resultado <= alu_H ? W'(alu_abc * alu_xis) : W'(alu_abc + alu_xis);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack"}, {31'd0, ack0 | ack1}, 0);
        check({tag, "_done"}, {31'd0, done0 | done1}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_res0"}, {16'd0, res0}, 0);
        check({tag, "_res1"}, {16'd0, res1}, 0);
        check({tag, "_alu"}, {alu_abc, alu_xis}, 0);
        check({tag, "_aluH"}, {31'd0, alu_H}, 0);
    endtask

    task automatic op(input bit c, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit o, input logic [W-1:0] e);
        @(negedge clk);
        if (c) begin req1 = 1'b1; a1 = a; b1 = b; op1 = o; end
        else   begin req0 = 1'b1; a0 = a; b0 = b; op0 = o; end
        @(negedge clk);
        check("ack", {31'd0, c ? ack1 : ack0}, 1);
        check("ack_other", {31'd0, c ? ack0 : ack1}, 0);
        check("busy_issue", {31'd0, busy}, 1);
        check("alu_abc", {16'd0, alu_abc}, {16'd0, a});
        check("alu_xis", {16'd0, alu_xis}, {16'd0, b});
        check("alu_H", {31'd0, alu_H}, {31'd0, o});
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check("ack_pulse", {31'd0, ack0 | ack1}, 0);
        check("busy_capture", {31'd0, busy}, 1);
        check("done_early", {31'd0, done0 | done1}, 0);
        @(negedge clk);
        if (c) er1 = e; else er0 = e;
        check("done", {31'd0, c ? done1 : done0}, 1);
        check("done_other", {31'd0, c ? done0 : done1}, 0);
        check("busy_idle", {31'd0, busy}, 0);
        check("res0", {16'd0, res0}, {16'd0, er0});
        check("res1", {16'd0, res1}, {16'd0, er1});
        @(negedge clk);
        check("done_pulse", {31'd0, done0 | done1}, 0);
        check("res0_hold", {16'd0, res0}, {16'd0, er0});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_zero("reset");
        op(0, 16'd2, 16'd3, 1, 16'd6);
        op(1, 16'hFFFF, 16'd2, 0, 16'h0001);
        op(0, 16'd300, 16'd300, 1, 16'h5F90);
        op(0, 16'h0100, 16'h0100, 1, 16'h0000);
        // Both clients requesting continuously right after reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a0 = 16'd7;   b0 = 16'd6;  op0 = 1'b1;
        a1 = 16'd100; b1 = 16'd23; op1 = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("rr_ack0", {31'd0, ack0}, {31'd0, k % 6 == 0});
            check("rr_ack1", {31'd0, ack1}, {31'd0, k % 6 == 3});
            check("rr_done0", {31'd0, done0}, {31'd0, k % 6 == 2});
            check("rr_done1", {31'd0, done1}, {31'd0, k % 6 == 5});
            check("rr_busy", {31'd0, busy}, {31'd0, k % 3 != 2});
            if (k % 6 == 2) check("rr_res0", {16'd0, res0}, 42);
            if (k % 6 == 5) check("rr_res1", {16'd0, res1}, 123);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        // Reset during CAPTURE of a client-1 operation
        @(negedge clk);
        req1 = 1'b1; a1 = 16'd5; b1 = 16'd5; op1 = 1'b0;
        @(negedge clk);
        check("rst_ack1", {31'd0, ack1}, 1);
        req1 = 1'b0;
        @(negedge clk);
        check("rst_in_capture", {31'd0, busy}, 1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
        a0 = 16'd2; b0 = 16'd3; op0 = 1'b1;
        a1 = 16'd9; b1 = 16'd9; op1 = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        @(negedge clk);
        check("tie_ack0", {31'd0, ack0}, 1);
        check("tie_ack1", {31'd0, ack1}, 0);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("tie_done0", {31'd0, done0}, 1);
        check("tie_done1", {31'd0, done1}, 0);
        check("tie_res0", {16'd0, res0}, 6);
        check("tie_res1", {16'd0, res1}, 0);
        er0 = 16'd6;
        er1 = 16'd0;
        op(1, 16'd10, 16'd20, 0, 16'd30);
        op(1, 16'd3, 16'd4, 1, 16'd12);
        op(1, 16'h8000, 16'h8000, 0, 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
